dual_issue_buffer: RTL and testbench

- Registered FIFO of decoded instruction pairs between decode and the Issue Unit, which steers slots to the branch pipe and the memory pipe.
- Every cycle it presents the head pair, one slot per output lane.
- A pair that cannot issue together is split over two cycles. Causes:
  - intra-pair RAW dependency
  - two memory ops in one pair (only one memory pipe exists)
  - a control-transfer instruction in slot 0
- Also absorbs backpressure from issue and supports a full flush on redirect.

---
 rtl/dual_issue_buffer_if.sv | 40 ++++
 rtl/dual_issue_buffer.sv | 148 ++++++++++++++
 tb/tb_dual_issue_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_buffer_if.sv
// Decode-to-issue bundle for the dual-issue buffer: incoming pair, presented lanes,
// the redirect flush and the occupancy count.
interface dual_issue_buffer_if #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 160
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_slot_v;
  logic [1:0][PAYLOAD_W-1:0]  in_payload;
  logic [1:0][4:0]            in_rd;
  logic [1:0][4:0]            in_rs1;
  logic [1:0][4:0]            in_rs2;
  logic [1:0]                 in_use_rs1;
  logic [1:0]                 in_use_rs2;
  logic [1:0]                 in_rf_we;
  logic [1:0]                 in_is_mem;
  logic [1:0]                 in_is_ctrl;
  logic                       issue_ready;
  logic [1:0]                 out_v;
  logic [1:0][PAYLOAD_W-1:0]  out_payload;
  logic [1:0][4:0]            out_rd;
  logic [1:0]                 out_is_mem;
  logic [CNT_W-1:0]           count;

  modport master (
    output flush, in_valid, in_slot_v, in_payload, in_rd, in_rs1, in_rs2,
           in_use_rs1, in_use_rs2, in_rf_we, in_is_mem, in_is_ctrl, issue_ready,
    input  in_ready, out_v, out_payload, out_rd, out_is_mem, count
  );

  modport slave (
    input  flush, in_valid, in_slot_v, in_payload, in_rd, in_rs1, in_rs2,
           in_use_rs1, in_use_rs2, in_rf_we, in_is_mem, in_is_ctrl, issue_ready,
    output in_ready, out_v, out_payload, out_rd, out_is_mem, count
  );
endinterface

// File: rtl/dual_issue_buffer.sv
// FIFO of decoded instruction pairs feeding the Issue Unit; pairs that cannot
// dual-issue (intra-pair RAW, two memory ops, control in slot 0) go out over two cycles.
module dual_issue_buffer #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 160
) (
  input  logic                clk,
  input  logic                rst,
  dual_issue_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // The split decision only depends on the pair itself, so it is resolved once at push.
  typedef struct packed {
    logic [1:0]                slot_v;
    logic [1:0][PAYLOAD_W-1:0] payload;
    logic [1:0][4:0]           rd;
    logic [1:0]                is_mem;
    logic                      split;
  } entry_t;

  typedef enum logic {PAIR, SECOND} state_t;

  entry_t                    mem_q [DEPTH];
  entry_t                    mem_d [DEPTH];
  entry_t                    in_entry;
  entry_t                    head;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  state_t                    state_q, state_d;
  logic                      push;
  logic                      pop;
  logic                      raw_hazard;
  logic                      in_ready_c;
  logic [1:0]                out_v_c;
  logic [1:0][PAYLOAD_W-1:0] lane_payload;
  logic [1:0][4:0]           lane_rd;
  logic [1:0]                lane_mem;
  logic                      unused_inputs;

  assign unused_inputs = ^{bus.in_rs1[0], bus.in_rs2[0], bus.in_use_rs1[0],
                           bus.in_use_rs2[0], bus.in_rf_we[1], bus.in_is_ctrl[1]};

  assign head       = mem_q[rd_ptr_q];
  assign in_ready_c = (count_q != CNT_W'(DEPTH));

  always_comb begin
    raw_hazard = bus.in_rf_we[0] && (bus.in_rd[0] != 5'd0) &&
                 ((bus.in_use_rs1[1] && (bus.in_rs1[1] == bus.in_rd[0])) ||
                  (bus.in_use_rs2[1] && (bus.in_rs2[1] == bus.in_rd[0])));
    in_entry.slot_v  = bus.in_slot_v;
    in_entry.payload = bus.in_payload;
    in_entry.rd      = bus.in_rd;
    in_entry.is_mem  = bus.in_is_mem;
    in_entry.split   = (bus.in_slot_v == 2'b11) &&
                       (raw_hazard || (bus.in_is_mem == 2'b11) || bus.in_is_ctrl[0]);
    push = bus.in_valid && in_ready_c && (|bus.in_slot_v) && !bus.flush;
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    out_v_c      = 2'b00;
    lane_payload = head.payload;
    lane_rd      = head.rd;
    lane_mem     = head.is_mem;
    unique case (state_q)
      PAIR: begin
        if (count_q != '0) begin
          if (head.split) begin
            out_v_c = 2'b01;
            if (bus.issue_ready) state_d = SECOND;
          end else begin
            out_v_c = head.slot_v;
            pop     = bus.issue_ready;
          end
        end
      end
      SECOND: begin
        out_v_c         = 2'b01;
        lane_payload[0] = head.payload[1];
        lane_rd[0]      = head.rd[1];
        lane_mem[0]     = head.is_mem[1];
        if (bus.issue_ready) begin
          pop     = 1'b1;
          state_d = PAIR;
        end
      end
      default: state_d = PAIR;
    endcase
    if (bus.flush) begin
      out_v_c = 2'b00;
      pop     = 1'b0;
      state_d = PAIR;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PAIR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is presented while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_v       = out_v_c;
  assign bus.out_payload = lane_payload;
  assign bus.out_rd      = lane_rd;
  assign bus.out_is_mem  = lane_mem & out_v_c;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_dual_issue_buffer.sv
// Directed bench for dual_issue_buffer: every accepted pair is expanded into the
// issue beats it should produce, and each consumed beat is compared against the lanes.
module tb_dual_issue_buffer;
  localparam int DEPTH = 4;
  localparam int PW    = 160;

  typedef struct {
    logic [1:0]         sv;
    logic [1:0][PW-1:0] pay;
    logic [1:0][4:0]    rd;
    logic [1:0][4:0]    rs1;
    logic [1:0][4:0]    rs2;
    logic [1:0]         use1;
    logic [1:0]         use2;
    logic [1:0]         we;
    logic [1:0]         mem;
    logic [1:0]         ctrl;
  } pair_t;

  typedef struct {
    logic [1:0]         v;
    logic [1:0][PW-1:0] pay;
    logic [1:0][4:0]    rd;
    logic [1:0]         mem;
    bit                 last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  beat_t exp_q[$];
  int    model_cnt = 0;
  int    checks    = 0;
  int    failures  = 0;

  always #5 clk = ~clk;

  dual_issue_buffer_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) bus ();

  dual_issue_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic pair_t mk(logic [7:0] tag, logic [1:0] sv, logic [4:0] rd0, logic [4:0] rd1,
                               logic [4:0] rs1b, logic [4:0] rs2b, logic [1:0] use1,
                               logic [1:0] use2, logic [1:0] we, logic [1:0] mem,
                               logic [1:0] ctrl);
    pair_t p;
    for (int i = 0; i < 2; i++) p.pay[i] = {5{tag, 8'(i), 16'hC3A5}};
    p.sv   = sv;
    p.rd   = {rd1, rd0};
    p.rs1  = {rs1b, 5'd31};
    p.rs2  = {rs2b, 5'd30};
    p.use1 = use1;
    p.use2 = use2;
    p.we   = we;
    p.mem  = mem;
    p.ctrl = ctrl;
    return p;
  endfunction

  // Reference expansion of one accepted pair into its issue beats.
  function automatic void expand(pair_t p);
    beat_t b;
    logic  raw, hz;
    raw = p.we[0] && (p.rd[0] != 5'd0) &&
          ((p.use1[1] && (p.rs1[1] == p.rd[0])) || (p.use2[1] && (p.rs2[1] == p.rd[0])));
    hz  = (p.sv == 2'b11) && (raw || (p.mem == 2'b11) || p.ctrl[0]);
    if (hz) begin
      b.v = 2'b01; b.pay = '0; b.rd = '0;
      b.pay[0] = p.pay[0]; b.rd[0] = p.rd[0]; b.mem = {1'b0, p.mem[0]}; b.last = 1'b0;
      exp_q.push_back(b);
      b.pay[0] = p.pay[1]; b.rd[0] = p.rd[1]; b.mem = {1'b0, p.mem[1]}; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      b.v = p.sv; b.pay = p.pay; b.rd = p.rd; b.mem = p.mem & p.sv; b.last = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  task automatic checkOutput(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare, then update the model.
  task automatic applyStimulus(pair_t p, bit valid, bit ready, bit fl);
    logic [1:0] ev;
    beat_t      b;
    int         cnt0;
    @(negedge clk);
    bus.in_valid    = valid;
    bus.in_slot_v   = p.sv;
    bus.in_payload  = p.pay;
    bus.in_rd       = p.rd;
    bus.in_rs1      = p.rs1;
    bus.in_rs2      = p.rs2;
    bus.in_use_rs1  = p.use1;
    bus.in_use_rs2  = p.use2;
    bus.in_rf_we    = p.we;
    bus.in_is_mem   = p.mem;
    bus.in_is_ctrl  = p.ctrl;
    bus.issue_ready = ready;
    bus.flush       = fl;
    #1;
    ev = (fl || exp_q.size() == 0) ? 2'b00 : exp_q[0].v;
    checkOutput("out_v", bus.out_v, ev);
    checkOutput("count", bus.count, model_cnt);
    checkOutput("in_ready", bus.in_ready, model_cnt != DEPTH);
    if (ev != 2'b00) begin
      b = exp_q[0];
      if (ev[0]) begin
        checkOutput("lane0_payload", bus.out_payload[0], b.pay[0]);
        checkOutput("lane0_rd", bus.out_rd[0], b.rd[0]);
      end
      if (ev[1]) begin
        checkOutput("lane1_payload", bus.out_payload[1], b.pay[1]);
        checkOutput("lane1_rd", bus.out_rd[1], b.rd[1]);
      end
      checkOutput("out_is_mem", bus.out_is_mem, b.mem);
    end
    cnt0 = model_cnt;
    if (fl) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (ready && exp_q.size() > 0) begin
        if (exp_q[0].last) model_cnt--;
        void'(exp_q.pop_front());
      end
      if (valid && cnt0 != DEPTH && (|p.sv)) begin
        expand(p);
        model_cnt++;
      end
    end
  endtask

  initial begin
    pair_t idle, p_addsub, p_raw, p_raw2, p_nowe, p_x0, p_lwsw, p_lwadd, p_ctrl0, p_ctrl1,
           p_lone, p_none;
    idle     = mk(8'h00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    p_addsub = mk(8'h10, 2'b11, 5'd5, 5'd6, 5'd1, 5'd2, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
    p_raw    = mk(8'h20, 2'b11, 5'd7, 5'd8, 5'd7, 5'd3, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
    p_raw2   = mk(8'h22, 2'b11, 5'd9, 5'd4, 5'd1, 5'd9, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
    p_nowe   = mk(8'h23, 2'b11, 5'd9, 5'd4, 5'd9, 5'd9, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00);
    p_x0     = mk(8'h21, 2'b11, 5'd0, 5'd8, 5'd0, 5'd3, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
    p_lwsw   = mk(8'h30, 2'b11, 5'd9, 5'd0, 5'd2, 5'd3, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00);
    p_lwadd  = mk(8'h31, 2'b11, 5'd9, 5'd10, 5'd4, 5'd5, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00);
    p_ctrl0  = mk(8'h32, 2'b11, 5'd0, 5'd11, 5'd1, 5'd2, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01);
    p_ctrl1  = mk(8'h33, 2'b11, 5'd12, 5'd0, 5'd1, 5'd2, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10);
    p_lone   = mk(8'h40, 2'b10, 5'd3, 5'd12, 5'd1, 5'd2, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00);
    p_none   = mk(8'h41, 2'b00, 5'd3, 5'd12, 5'd1, 5'd2, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);

    // Reset held with a valid pair on the input.
    bus.in_valid    = 1'b1;
    bus.in_slot_v   = p_addsub.sv;
    bus.in_payload  = p_addsub.pay;
    bus.in_rd       = p_addsub.rd;
    bus.in_rs1      = p_addsub.rs1;
    bus.in_rs2      = p_addsub.rs2;
    bus.in_use_rs1  = p_addsub.use1;
    bus.in_use_rs2  = p_addsub.use2;
    bus.in_rf_we    = p_addsub.we;
    bus.in_is_mem   = p_addsub.mem;
    bus.in_is_ctrl  = p_addsub.ctrl;
    bus.issue_ready = 1'b1;
    bus.flush       = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("reset_out_v", bus.out_v, 2'b00);
      checkOutput("reset_count", bus.count, 0);
    end
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;

    // Basic pair, then RAW splits and their non-split counterparts.
    applyStimulus(p_addsub, 1, 0, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(p_raw,    1, 1, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(p_x0,     1, 1, 0);
    applyStimulus(p_raw2,   1, 1, 0);
    applyStimulus(p_nowe,   1, 1, 0);
    applyStimulus(idle,     0, 0, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(idle,     0, 1, 0);

    // Memory-pipe conflicts, control transfers, lone slot 1, empty-slot push.
    applyStimulus(p_lwsw,   1, 0, 0);
    applyStimulus(p_lwadd,  1, 1, 0);
    applyStimulus(p_ctrl0,  1, 1, 0);
    applyStimulus(p_ctrl1,  1, 1, 0);
    applyStimulus(p_lone,   1, 1, 0);
    applyStimulus(p_none,   1, 1, 0);
    repeat (6) applyStimulus(idle, 0, 1, 0);

    // Fill under backpressure, refuse a fifth pair, then stream with pointer wrap.
    for (int k = 0; k < 5; k++)
      applyStimulus(mk(8'h50 + 8'(k), 2'b11, 5'(13 + k), 5'd20, 5'd1, 5'd2,
                       2'b11, 2'b11, 2'b11, 2'b00, 2'b00), 1, 0, 0);
    for (int k = 0; k < 6; k++)
      applyStimulus(mk(8'h60 + 8'(k), 2'b11, 5'(21 + k), 5'd22, 5'd1, 5'd2,
                       2'b11, 2'b11, 2'b11, 2'b00, 2'b00), 1, 1, 0);
    repeat (5) applyStimulus(idle, 0, 1, 0);

    // Flush while the head pair is in its second half with three pairs held.
    applyStimulus(p_raw,    1, 0, 0);
    applyStimulus(p_lwadd,  1, 0, 0);
    applyStimulus(p_addsub, 1, 0, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(p_x0,     1, 1, 1);
    applyStimulus(idle,     0, 0, 0);
    applyStimulus(p_addsub, 1, 0, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(idle,     0, 1, 0);

    // Asynchronous reset in the middle of a split.
    applyStimulus(p_lwsw,   1, 0, 0);
    applyStimulus(p_lwadd,  1, 1, 0);
    applyStimulus(idle,     0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_out_v", bus.out_v, 2'b00);
    checkOutput("async_rst_count", bus.count, 0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(p_addsub, 1, 1, 0);
    applyStimulus(idle,     0, 1, 0);
    applyStimulus(idle,     0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
